// File: rtl/id_stage_pipe.sv
// id_stage_pipe: MIPS instruction-decode stage with an integrated ID/EX
// pipeline register. Decodes the opcode into WB/MEM/EX control bundles,
// reads a 2R/1W register file, sign-extends the immediate, detects load-use
// hazards (stalling IF) and honours a branch flush.
// Optional feature macro: ID_WB_BYPASS_EN (same-cycle WB write-through on reads).
module id_stage_pipe #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int ZERO_REG = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_valid,
    input  logic [31:0]     i_ins,
    input  logic [XLEN-1:0] i_npc,
    input  logic            i_flush,
    input  logic            i_wb_we,
    input  logic [4:0]      i_wb_addr,
    input  logic [XLEN-1:0] i_wb_data,
    output logic            o_stall,
    output logic            o_valid,
    output logic [1:0]      o_sig_wb,
    output logic [2:0]      o_sig_mem,
    output logic [3:0]      o_sig_ex,
    output logic [XLEN-1:0] o_rd1,
    output logic [XLEN-1:0] o_rd2,
    output logic [XLEN-1:0] o_imm,
    output logic [4:0]      o_rs,
    output logic [4:0]      o_rt,
    output logic [4:0]      o_rd,
    output logic [XLEN-1:0] o_npc,
    output logic            o_illegal
);

    typedef enum logic [5:0] {
        OP_RTYPE = 6'b000000,
        OP_BEQ   = 6'b000100,
        OP_ADDI  = 6'b001000,
        OP_LW    = 6'b100011,
        OP_SW    = 6'b101011
    } opcodeT;

    // Control bundle produced by the decoder for one instruction.
    typedef struct packed {
        logic [1:0] wb;      // {MemtoReg, RegWrite}
        logic [2:0] mem;     // {MemRead, MemWrite, Branch}
        logic [3:0] ex;      // {ALUOp[1:0], ALUSrc, RegDst}
        logic       illegal;
    } ctrlT;

    localparam logic [5:0] REG_LIMIT = 6'(NUM_REGS);

    logic [XLEN-1:0] regFile [NUM_REGS];

    opcodeT          opcode;
    logic [4:0]      rsIdx;
    logic [4:0]      rtIdx;
    logic [4:0]      rdIdx;
    ctrlT            ctrl;
    logic            wbLegal;
    logic            usesRt;
    logic            loadUse;
    logic            loadBubble;
    logic [XLEN-1:0] rsData;
    logic [XLEN-1:0] rtData;
    logic [XLEN-1:0] immExt;

    assign opcode = opcodeT'(i_ins[31:26]);
    assign rsIdx  = i_ins[25:21];
    assign rtIdx  = i_ins[20:16];
    assign rdIdx  = i_ins[15:11];

    // A write lands only for implemented registers, never on a hardwired r0.
    assign wbLegal = i_wb_we && ({1'b0, i_wb_addr} < REG_LIMIT)
                     && !((ZERO_REG != 0) && (i_wb_addr == 5'd0));

    // Sign-extend the 16-bit immediate to the datapath width.
    generate
        if (XLEN > 16) begin : gExt
            assign immExt = {{(XLEN-16){i_ins[15]}}, i_ins[15:0]};
        end else begin : gNoExt
            assign immExt = i_ins[15:0];
        end
    endgenerate

    // Opcode decode into the three control bundles; unknown opcodes are flagged.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
        ctrl   = '0;
        usesRt = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                ctrl.ex = 4'b1001; ctrl.mem = 3'b000; ctrl.wb = 2'b01; usesRt = 1'b1;
            end
            OP_LW: begin
                ctrl.ex = 4'b0010; ctrl.mem = 3'b100; ctrl.wb = 2'b11;
            end
            OP_SW: begin
                ctrl.ex = 4'b0010; ctrl.mem = 3'b010; ctrl.wb = 2'b00; usesRt = 1'b1;
            end
            OP_BEQ: begin
                ctrl.ex = 4'b0100; ctrl.mem = 3'b001; ctrl.wb = 2'b00; usesRt = 1'b1;
            end
            OP_ADDI: begin
                ctrl.ex = 4'b0010; ctrl.mem = 3'b000; ctrl.wb = 2'b01;
            end
            default: ctrl.illegal = 1'b1;
        endcase
    end

    // Combinational register reads, optionally writing through a pending WB write.
    always_comb begin
        rsData = '0;
        rtData = '0;
        if ({1'b0, rsIdx} < REG_LIMIT) rsData = regFile[rsIdx];
        if ({1'b0, rtIdx} < REG_LIMIT) rtData = regFile[rtIdx];
`ifdef ID_WB_BYPASS_EN
        if (wbLegal && (i_wb_addr == rsIdx)) rsData = i_wb_data;
        if (wbLegal && (i_wb_addr == rtIdx)) rtData = i_wb_data;
`endif
    end

    // Load-use hazard: the load in ID/EX produces a register this instruction reads.
    // rt is only a source for R-type, sw and beq; for lw/addi it is a destination.
    always_comb begin
        loadUse = o_valid && o_sig_mem[2] && (o_rt != 5'd0) && i_valid
                  && ((o_rt == rsIdx) || ((o_rt == rtIdx) && usesRt));
        // A flush squashes the dependent instruction, so there is nothing to hold.
        o_stall = loadUse && !i_flush && !rst;
    end

    assign loadBubble = i_flush || o_stall || !i_valid;

    // Register file: asynchronously cleared, written from WB regardless of stall/flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the register file must clear asynchronously, so it is built from resettable flops rather than a RAM macro.
            for (int i = 0; i < NUM_REGS; i++) regFile[i] <= '0;
        end else if (wbLegal) begin
            regFile[i_wb_addr] <= i_wb_data;
        end
    end

    // ID/EX pipeline register: load the decoded instruction or insert a zeroed bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            o_valid   <= 1'b0;
            o_sig_wb  <= '0;
            o_sig_mem <= '0;
            o_sig_ex  <= '0;
            o_rd1     <= '0;
            o_rd2     <= '0;
            o_imm     <= '0;
            o_rs      <= '0;
            o_rt      <= '0;
            o_rd      <= '0;
            o_npc     <= '0;
            o_illegal <= 1'b0;
        end else if (loadBubble) begin
            o_valid   <= 1'b0;
            o_sig_wb  <= '0;
            o_sig_mem <= '0;
            o_sig_ex  <= '0;
            o_rd1     <= '0;
            o_rd2     <= '0;
            o_imm     <= '0;
            o_rs      <= '0;
            o_rt      <= '0;
            o_rd      <= '0;
            o_npc     <= '0;
            o_illegal <= 1'b0;
        end else begin
            o_valid   <= 1'b1;
            o_sig_wb  <= ctrl.wb;
            o_sig_mem <= ctrl.mem;
            o_sig_ex  <= ctrl.ex;
            o_rd1     <= rsData;
            o_rd2     <= rtData;
            o_imm     <= immExt;
            o_rs      <= rsIdx;
            o_rt      <= rtIdx;
            o_rd      <= rdIdx;
            o_npc     <= i_npc;
            o_illegal <= ctrl.illegal;
        end
    end

endmodule
